// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word geometry, bubble encoding
// and the IF/ID pipeline-register payload used by fetch and decode.
package mips_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam logic [WORD_W-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INCR   = 32'd4;
  localparam logic [WORD_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  // Empty pipeline slot carrying the chosen NOP encoding.
  function automatic if_id_t make_bubble(input logic [WORD_W-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold and flush; flush beats hold, and reset or flush
// both leave a bubble in the slot.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = make_bubble(NOP_INSTR);

  if_id_t slot_d, slot_q;

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = BUBBLE;
    end else if (!hold) begin
      slot_d = d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID register for decode.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       IMEM_DEPTH = 32,
  parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              fetch_fault
);

  localparam logic [WORD_W-1:0] IMEM_WORDS = WORD_W'(IMEM_DEPTH);

  logic [WORD_W-1:0] pc_d, pc_q;
  logic              fault_d, fault_q;
  logic [WORD_W-1:0] pc_plus4;
  logic              in_range;
  logic              ifid_hold, ifid_flush;
  if_id_t            ifid_d, ifid_q;

  assign pc_plus4 = pc_q + PC_INCR;
  assign in_range = {2'b00, pc_q[WORD_W-1:2]} < IMEM_WORDS;

  // Priority redirect > stall > fetch; an out-of-range fetch parks the PC so
  // the stage idles on bubbles until a redirect brings it back in range.
  always_comb begin
    pc_d       = pc_q;
    fault_d    = fault_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect) begin
      pc_d       = redirect_pc & WORD_MASK;
      ifid_flush = 1'b1;
    end else if (stall) begin
      ifid_hold  = 1'b1;
    end else if (in_range) begin
      pc_d       = pc_plus4;
    end else begin
      ifid_flush = 1'b1;
      fault_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign ifid_d.instr    = imem_instr;
  assign ifid_d.pc_plus4 = pc_plus4;
  assign ifid_d.valid    = 1'b1;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (ifid_hold),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
  assign if_id_valid    = ifid_q.valid;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: expected PC / IF/ID / fault are queued as
// each cycle is driven and compared one edge later.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    if_id_t      ifid;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  if_id_t      m_ifid;
  logic        m_fault;
  if_id_t      bubble;

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (32),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a[31:2] < 30'd32) return 32'hA000_0000 + {2'b00, a[31:2]};
    return 32'hDEAD_BEEF;
  endfunction

  assign #1 imem_instr = mem_read(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  imem_addr,      32'h0);
    check({tag, "_instr"}, if_id_instr,    32'h0);
    check({tag, "_pc4"},   if_id_pc_plus4, 32'h0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_ifid  = bubble;
    m_fault = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle, queue what the spec says should be visible after the
  // edge, then pop and compare once the edge has passed.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (rd) begin
      m_pc   = {rpc[31:2], 2'b00};
      m_ifid = bubble;
    end else if (st) begin
      // everything holds
    end else if (m_pc[31:2] < 30'd32) begin
      m_ifid.instr    = 32'hA000_0000 + {2'b00, m_pc[31:2]};
      m_ifid.pc_plus4 = m_pc + 32'd4;
      m_ifid.valid    = 1'b1;
      m_pc            = m_pc + 32'd4;
    end else begin
      m_ifid  = bubble;
      m_fault = 1'b1;
    end
    e.pc = m_pc; e.ifid = m_ifid; e.fault = m_fault;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("addr",  imem_addr,      e.pc);
      check("instr", if_id_instr,    e.ifid.instr);
      check("pc4",   if_id_pc_plus4, e.ifid.pc_plus4);
      check("valid", {31'd0, if_id_valid}, {31'd0, e.ifid.valid});
      check("fault", {31'd0, fetch_fault}, {31'd0, e.fault});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bubble = make_bubble(32'h0);
    model_reset();

    // Reset values appear without any clock edge, and persist through one.
    #1 reset = 1'b1;
    #2 check_reset_vals("rst_async");
    #4 check_reset_vals("rst_edge");
    #1 reset = 1'b0;

    // Sequential fetch
    step(0, 0, 0);
    check("seq0_instr", if_id_instr, 32'hA000_0000);
    step(0, 0, 0);
    check("seq1_addr", imem_addr, 32'h8);
    check("seq1_pc4",  if_id_pc_plus4, 32'h8);

    // Stall hold at imem_addr = 8
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("stall_instr", if_id_instr, 32'hA000_0001);
    step(0, 0, 0);
    check("unstall_instr", if_id_instr, 32'hA000_0002);

    // Redirect from 12 to 0x42 (low bits dropped)
    check("pre_redir_addr", imem_addr, 32'hC);
    step(0, 1, 32'h0000_0042);
    check("redir_addr", imem_addr, 32'h40);
    step(0, 0, 0);
    check("redir_instr", if_id_instr, 32'hA000_0010);
    check("redir_pc4",   if_id_pc_plus4, 32'h44);

    // Redirect wins over stall
    step(1, 1, 32'h20);
    check("redir_stall_addr", imem_addr, 32'h20);
    step(0, 0, 0);

    // Out of range: last word then park at 0x80
    step(0, 1, 32'h7C);
    step(0, 0, 0);
    check("last_word", if_id_instr, 32'hA000_001F);
    step(0, 0, 0);
    check("oor_addr",  imem_addr, 32'h80);
    check("oor_fault", {31'd0, fetch_fault}, 32'd1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 32'h0);
    step(0, 0, 0);
    check("resume_instr", if_id_instr, 32'hA000_0000);

    // Async reset mid-stall at pc 0x18
    step(0, 1, 32'h18);
    step(1, 0, 0);
    check("pre_rst_addr", imem_addr, 32'h18);
    #3 reset = 1'b1;
    #1 check_reset_vals("rst_mid");
    #1 reset = 1'b0;
    model_reset();
    step(0, 0, 0);
    check("restart_instr", if_id_instr, 32'hA000_0000);

    // Fault only sets on a non-stalled out-of-range edge
    step(0, 1, 32'h80);
    step(1, 0, 0);
    check("stall_oor_fault", {31'd0, fetch_fault}, 32'd0);
    step(0, 0, 0);
    step(0, 1, 32'h4);
    step(0, 0, 0);

    stall = 1'b0;
    redirect = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
